// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states, byte-lane
// constants and the big-endian byte selector used when serialising a word.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } ld_state_t;

  localparam int BYTES_PER_INSN = 4;
  localparam int DEF_MEM_BYTES  = 1024;

  // Byte lane 0 is the most-significant byte so that the lowest address holds
  // [31:24], matching how instruction fetch reassembles the word.
  function automatic logic [7:0] insn_byte(input logic [31:0] word,
                                           input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Byte-serial instruction-memory writer. Takes 32-bit words over a valid/ready
// stream and writes each as four consecutive bytes, MSB first, while holding
// the CPU in reset for the duration of the load.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_BYTES = DEF_MEM_BYTES,
  parameter int CNT_W     = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [63:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_word,
  output logic             wr_en,
  output logic [63:0]      wr_addr,
  output logic [7:0]       wr_byte,
  output logic             busy,
  output logic             cpu_hold,
  output logic             done,
  output logic             error
);

  ld_state_t        state_q, state_d;
  logic [63:0]      addr_q,  addr_d;
  logic [CNT_W-1:0] rem_q,   rem_d;
  logic [31:0]      word_q,  word_d;
  logic [1:0]       idx_q,   idx_d;
  logic             busy_q, done_q, error_q;
  logic             err_d;

  // Range check done in 65 bits so a base near the top of the 64-bit space
  // cannot wrap around and look like it fits.
  logic [64:0] end_addr;
  logic        bad_start;

  assign end_addr  = {1'b0, base_addr}
                   + {{(65-CNT_W-2){1'b0}}, word_count, 2'b00};
  assign bad_start = (base_addr[1:0] != 2'b00) || (end_addr > 65'(MEM_BYTES));

  // Next-state and datapath updates; start is only looked at in IDLE and
  // in_valid only in ACCEPT, so both are ignored everywhere else.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    word_d  = word_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (bad_start) begin
            err_d = 1'b1;
          end else if (word_count == '0) begin
            state_d = S_DONE;
          end else begin
            addr_d  = base_addr;
            rem_d   = word_count;
            state_d = S_ACCEPT;
          end
        end
      end
      S_ACCEPT: begin
        if (in_valid) begin
          word_d  = in_word;
          idx_d   = 2'd0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d = addr_q + 64'd1;
        idx_d  = idx_q + 2'd1;
        if (idx_q == 2'(BYTES_PER_INSN - 1)) begin
          rem_d   = rem_q - CNT_W'(1);
          state_d = (rem_q == CNT_W'(1)) ? S_DONE : S_ACCEPT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and the registered status flags. Status flags are
  // computed from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      error_q <= err_d;
    end
  end

  // Stream and memory-port outputs decode registered state only; the write
  // bus is forced to zero outside WRITE so idle cycles present a clean port.
  always_comb begin
    in_ready = (state_q == S_ACCEPT);
    wr_en    = (state_q == S_WRITE);
    wr_addr  = wr_en ? addr_q : 64'd0;
    wr_byte  = wr_en ? insn_byte(word_q, idx_q) : 8'd0;
  end

  assign busy     = busy_q;
  assign cpu_hold = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised self-checking bench for imem_loader. Expected byte streams,
// accept/reject decisions and timing come from a word-level model of the load.
module tb_imem_loader;

  localparam int MEMB = 1024;
  localparam int CW   = 9;

  logic          clk;
  logic          reset;
  logic          start;
  logic [63:0]   base_addr;
  logic [CW-1:0] word_count;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_word;
  logic          wr_en;
  logic [63:0]   wr_addr;
  logic [7:0]    wr_byte;
  logic          busy;
  logic          cpu_hold;
  logic          done;
  logic          error;

  imem_loader #(.MEM_BYTES(MEMB), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word    (in_word),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_byte    (wr_byte),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] wlog_a[$];
  logic [7:0]  wlog_d[$];
  logic [7:0]  mem[0:MEMB-1];
  logic [31:0] preset[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock; sample 1ns after the edge and log the write the port presents.
  task automatic tick();
    @(posedge clk);
    #1;
    if (wr_en === 1'b1) begin
      wlog_a.push_back(wr_addr);
      wlog_d.push_back(wr_byte);
      if (wr_addr < 64'(MEMB)) mem[wr_addr[9:0]] = wr_byte;
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [31:0] w, input int lane);
    return 8'((w >> (8 * (3 - lane))) & 32'hFF);
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_wren"},  64'(wr_en),    64'd0);
    chk({tag, "_waddr"}, wr_addr,       64'd0);
    chk({tag, "_wbyte"}, 64'(wr_byte),  64'd0);
    chk({tag, "_busy"},  64'(busy),     64'd0);
    chk({tag, "_hold"},  64'(cpu_hold), 64'd0);
    chk({tag, "_done"},  64'(done),     64'd0);
    chk({tag, "_err"},   64'(error),    64'd0);
  endtask

  // Runs one start request end-to-end and compares against the model.
  // vmode: 0 in_valid always high, 1 toggling, 2 random. spam re-pulses
  // start with junk parameters every cycle while the load is running.
  task automatic run_case(input logic [63:0] base, input int cnt,
                          input int vmode, input bit spam);
    logic [31:0] words[$];
    bit rej, hs;
    int t, widx, done_t, busy_gap, hold_gap;
    rej = (base[1:0] != 2'b00) ||
          (({1'b0, base} + 65'(4 * cnt)) > 65'(MEMB));
    words = {};
    for (int i = 0; i < cnt; i++)
      words.push_back((preset.size() > i) ? preset[i] : $urandom);
    wlog_a = {};
    wlog_d = {};

    start      = 1'b1;
    base_addr  = base;
    word_count = CW'(cnt);
    in_valid   = (vmode == 0);
    in_word    = $urandom;
    tick();
    start      = 1'b0;
    base_addr  = {$urandom, $urandom};
    word_count = CW'($urandom);

    if (rej) begin
      in_valid = 1'b0;
      chk("rej_err",   64'(error),    64'd1);
      chk("rej_busy",  64'(busy),     64'd0);
      chk("rej_ready", 64'(in_ready), 64'd0);
      tick();
      chk("rej_err_clr", 64'(error), 64'd0);
      chk("rej_busy2",   64'(busy),  64'd0);
      chk("rej_nowr",    64'(wlog_a.size()), 64'd0);
      return;
    end

    chk("acc_err",  64'(error),    64'd0);
    chk("busy_c1",  64'(busy),     64'd1);
    chk("hold_c1",  64'(cpu_hold), 64'd1);

    if (cnt == 0) begin
      in_valid = 1'b0;
      chk("zero_done", 64'(done), 64'd1);
      tick();
      chk("zero_done_clr", 64'(done), 64'd0);
      chk("zero_busy_clr", 64'(busy), 64'd0);
      chk("zero_nowr",     64'(wlog_a.size()), 64'd0);
      return;
    end

    chk("ready_c1", 64'(in_ready), 64'd1);
    t = 1; widx = 0; done_t = -1; busy_gap = 0; hold_gap = 0;
    while (done_t < 0 && t < 4000) begin
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = t[0];
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_word = (widx < cnt) ? words[widx] : $urandom;
      if (spam) begin
        start      = 1'b1;
        base_addr  = {$urandom, $urandom};
        word_count = CW'($urandom);
      end
      hs = in_valid && in_ready;
      tick();
      t++;
      if (hs) widx++;
      if (busy !== 1'b1) busy_gap++;
      if (cpu_hold !== busy) hold_gap++;
      if (done === 1'b1) done_t = t;
    end
    in_valid = 1'b0;
    start    = 1'b0;

    chk("done_seen",  64'(done_t >= 0), 64'd1);
    chk("words_used", 64'(widx),        64'(cnt));
    chk("busy_held",  64'(busy_gap),    64'd0);
    chk("hold_eq",    64'(hold_gap),    64'd0);
    if (vmode == 0) chk("done_time", 64'(done_t), 64'(5 * cnt + 1));
    chk("wr_count", 64'(wlog_a.size()), 64'(4 * cnt));
    for (int i = 0; i < wlog_a.size() && i < 4 * cnt; i++) begin
      chk("wr_addr", wlog_a[i],       base + 64'(i));
      chk("wr_byte", 64'(wlog_d[i]),  64'(exp_byte(words[i / 4], i % 4)));
    end
    tick();
    chk("done_clr", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [31:0] rw[$];
    logic [63:0] b;
    int c, r, widx;
    bit hs;

    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    in_valid = 1'b0; in_word = '0;
    for (int i = 0; i < MEMB; i++) mem[i] = 8'h00;
    repeat (3) tick();
    chk_idle_outputs("reset");
    reset = 1'b0;
    tick();

    // Single word at 0, then read it back the way fetch does.
    preset = {32'h00A00093};
    run_case(64'd0, 1, 0, 1'b0);
    preset = {};
    chk("fetch_pc0", 64'({mem[0], mem[1], mem[2], mem[3]}), 64'h00A00093);

    // Three words with a toggling valid.
    run_case(64'h10, 3, 1, 1'b0);

    // Boundary requests.
    run_case(64'h2,   1, 0, 1'b0);
    run_case(64'h3FC, 2, 0, 1'b0);
    run_case(64'h3FC, 1, 0, 1'b0);
    chk("last_byte_addr", wlog_a[wlog_a.size() - 1], 64'h3FF);
    run_case(64'h3F8, 2, 2, 1'b0);
    run_case(64'd0, 257, 0, 1'b0);
    run_case(64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 1'b0);
    run_case(64'h100, 0, 0, 1'b0);

    // Start spam while busy must not disturb the load.
    run_case(64'h80, 2, 0, 1'b1);

    // Reset in the middle of word 2, byte index 2.
    rw = {};
    for (int i = 0; i < 3; i++) rw.push_back($urandom);
    wlog_a = {}; wlog_d = {};
    start = 1'b1; base_addr = 64'h40; word_count = CW'(3);
    tick();
    start = 1'b0;
    widx = 0;
    c = 0;
    while (wlog_a.size() < 7 && c < 100) begin
      in_valid = 1'b1;
      in_word  = (widx < 3) ? rw[widx] : 32'h0;
      hs = in_valid && in_ready;
      tick();
      c++;
      if (hs) widx++;
    end
    chk("mid_wr_addr", wr_addr, 64'h46);
    reset = 1'b1; in_valid = 1'b0;
    tick();
    chk_idle_outputs("mid_rst");
    reset = 1'b0;
    tick();
    chk("mid_rst_nowr", 64'(wlog_a.size()), 64'd7);
    for (int i = 0; i < 7; i++)
      chk("mid_rst_mem", 64'(mem[64'h40 + i]), 64'(exp_byte(rw[i / 4], i % 4)));
    chk("mid_rst_idle", 64'(busy), 64'd0);
    run_case(64'h40, 2, 0, 1'b0);

    // Randomised mix of accepted, empty and rejected requests.
    for (int k = 0; k < 24; k++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        b = 64'($urandom_range(0, 1100));
        c = $urandom_range(0, 10);
      end else if (r == 2) begin
        b = {32'hFFFF_FFFF, 32'($urandom_range(0, 32'hFFFF_FFFF))} & ~64'h3;
        c = $urandom_range(1, 8);
      end else begin
        c = $urandom_range(0, 6);
        b = 64'(4 * $urandom_range(0, (MEMB / 4) - c));
      end
      run_case(b, c, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
